btn_cond: RTL

Input-conditioning stage placed between the board pins and the calculator top. It synchronises the five push-buttons and 16 slide switches into the `clk` domain and debounces each button with its own state machine. Each button gets a clean debounced level and a single-cycle press pulse, so one physical press of the accumulate button produces exactly one accumulator update. The calculator consumes `btn_level` for operation select and `btn_pulse` for clear and accumulate.

---
 rtl/btn_cond.sv | 131 +++++++++++++
 1 files changed

// File: rtl/btn_cond.sv
// Input conditioning: two-flop synchronisers for buttons and switches, plus a
// per-button debounce FSM producing a clean level and a one-cycle press pulse.
module btn_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn_raw,
    input  logic [15:0] sw_raw,
    output logic [4:0]  btn_level,
    output logic [4:0]  btn_pulse,
    output logic [15:0] sw_sync
);

    localparam int unsigned N_BTN = 5;
    localparam int unsigned N_SW  = 16;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    logic [N_BTN-1:0] r_btn_ff1;
    logic [N_BTN-1:0] r_btn_ff2;
    logic [N_SW-1:0]  r_sw_ff1;
    logic [N_SW-1:0]  r_sw_ff2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_ff1 <= '0;
            r_btn_ff2 <= '0;
            r_sw_ff1  <= '0;
            r_sw_ff2  <= '0;
        end else begin
            r_btn_ff1 <= btn_raw;
            r_btn_ff2 <= r_btn_ff1;
            r_sw_ff1  <= sw_raw;
            r_sw_ff2  <= r_sw_ff1;
        end
    end

    assign sw_sync = r_sw_ff2;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_level;
        logic             r_pulse;
        logic             w_level_nxt;
        logic             w_pulse_nxt;
        logic             w_s;

        assign w_s = r_btn_ff2[g];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // Counter is cleared on every state change, so it never passes C_LAST.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_pulse_nxt = 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        w_state_nxt = PRESS_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_LAST) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_s) begin
                        w_state_nxt = REL_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                REL_WAIT: begin
                    if (w_s) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

        assign btn_level[g] = r_level;
        assign btn_pulse[g] = r_pulse;
    end

endmodule
